add_serial: RTL and testbench

ADD_SERIAL -- requirements
Module: add_serial

---
 rtl/add_serial.sv | 117 +++++++++++
 tb/tb_add_serial.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/add_serial.sv
// Multi-cycle serial adder/subtractor: adds CHUNK bits per clock, LSB chunk first,
// and presents the registered result and flags when the last chunk completes.
module add_serial #(
  parameter int DATASIZE = 8,
  parameter int CHUNK    = 2
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iStart,
  input  logic [DATASIZE-1:0] iA,
  input  logic [DATASIZE-1:0] iB,
  input  logic                iCI,
  input  logic                iSub,
  output logic                oBusy,
  output logic                oDone,
  output logic [DATASIZE-1:0] oS,
  output logic                oCY,
  output logic                oAC,
  output logic                oZ,
  output logic                oSg,
  output logic                oP
);

  localparam int          NCHK   = DATASIZE / CHUNK;
  localparam int          KW     = (NCHK > 1) ? $clog2(NCHK) : 1;
  localparam int unsigned AC_POS = 3 % CHUNK;
  localparam logic [KW-1:0] K_LAST = KW'(NCHK - 1);
  localparam logic [KW-1:0] K_AC   = KW'(3 / CHUNK);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              r_state;
  logic [DATASIZE-1:0] r_a;
  logic [DATASIZE-1:0] r_b;
  logic [DATASIZE-1:0] r_work;
  logic                r_cy;
  logic                r_ac;
  logic                r_sub;
  logic [KW-1:0]       r_k;

  logic [CHUNK-1:0]    w_ca;
  logic [CHUNK-1:0]    w_cb;
  logic [CHUNK-1:0]    w_sum;
  logic                w_c;
  logic                w_c3;
  logic [DATASIZE-1:0] w_result;

  // Ripple across the current chunk; the carry out of bit 3 is tapped wherever it lands.
  always_comb begin
    w_ca  = r_a[r_k*CHUNK +: CHUNK];
    w_cb  = r_b[r_k*CHUNK +: CHUNK];
    w_sum = '0;
    w_c3  = 1'b0;
    w_c   = r_cy;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      w_sum[i] = w_ca[i] ^ w_cb[i] ^ w_c;
      w_c      = (w_ca[i] & w_cb[i]) | (w_c & (w_ca[i] ^ w_cb[i]));
      if (i == AC_POS) w_c3 = w_c;
    end
    w_result = r_work;
    w_result[(NCHK-1)*CHUNK +: CHUNK] = w_sum;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_cy    <= 1'b0;
      r_ac    <= 1'b0;
      r_sub   <= 1'b0;
      r_k     <= '0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oS      <= '0;
      oCY     <= 1'b0;
      oAC     <= 1'b0;
      oZ      <= 1'b0;
      oSg     <= 1'b0;
      oP      <= 1'b0;
    end else begin
      oDone <= 1'b0;
      if (r_state != RUN) begin
        // IDLE and DONE share the accept path so DONE can restart back-to-back.
        if (iStart) begin
          r_a     <= iA;
          r_b     <= iSub ? ~iB : iB;
          r_cy    <= iSub ? ~iCI : iCI;
          r_sub   <= iSub;
          r_k     <= '0;
          oBusy   <= 1'b1;
          r_state <= RUN;
        end else begin
          r_state <= IDLE;
        end
      end else begin
        r_work[r_k*CHUNK +: CHUNK] <= w_sum;
        r_cy <= w_c;
        r_k  <= r_k + 1'b1;
        if (r_k == K_AC) r_ac <= w_c3;
        if (r_k == K_LAST) begin
          oS      <= w_result;
          oCY     <= w_c ^ r_sub;
          oAC     <= (r_k == K_AC) ? w_c3 : r_ac;
          oZ      <= ~|w_result;
          oSg     <= w_result[DATASIZE-1];
          oP      <= ~^w_result;
          oBusy   <= 1'b0;
          oDone   <= 1'b1;
          r_state <= DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_add_serial.sv
// Self-checking bench for add_serial: vector table, scoreboard queue, handshake and reset corners.
module tb_add_serial;

  localparam int DW = 8;
  localparam int CW = 2;
  localparam int NC = DW / CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] a, b;
  logic          ci, sub;
  logic          busy, done, cy, ac, z, sg, p;
  logic [DW-1:0] s;

  logic          start16;
  logic [15:0]   a16, b16, s16;
  logic          ci16, sub16;
  logic          busy16, done16, cy16, ac16, z16, sg16, p16;

  always #5 clk = ~clk;

  add_serial #(.DATASIZE(DW), .CHUNK(CW)) dut (
    .iClk(clk), .iRst(rst), .iStart(start), .iA(a), .iB(b), .iCI(ci), .iSub(sub),
    .oBusy(busy), .oDone(done), .oS(s), .oCY(cy), .oAC(ac), .oZ(z), .oSg(sg), .oP(p)
  );

  add_serial #(.DATASIZE(16), .CHUNK(4)) dut16 (
    .iClk(clk), .iRst(rst), .iStart(start16), .iA(a16), .iB(b16), .iCI(ci16), .iSub(sub16),
    .oBusy(busy16), .oDone(done16), .oS(s16), .oCY(cy16), .oAC(ac16), .oZ(z16), .oSg(sg16), .oP(p16)
  );

  typedef struct packed {
    logic [DW-1:0] s;
    logic cy, ac, z, sg, p;
  } res_t;

  typedef struct {
    logic [DW-1:0] a, b;
    logic          ci, sub;
    res_t          exp;
  } vec_t;

  res_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every oDone pulse must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got=done with empty queue want=no done");
      end else begin
        check("result", 32'({s, cy, ac, z, sg, p}), 32'(q.pop_front()));
      end
    end
  end

  task automatic start_op(input logic [DW-1:0] ta, input logic [DW-1:0] tb,
                          input logic tci, input logic tsub, input res_t e, input bit push);
    @(negedge clk);
    a = ta; b = tb; ci = tci; sub = tsub; start = 1'b1;
    if (push) q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = DW'($urandom); b = DW'($urandom); ci = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_done(output int busy_n, output int lat);
    bit seen = 0;
    busy_n = 0;
    lat = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) seen = 1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got=no done want=done within 20 cycles");
    end
  endtask

  vec_t vt[8];
  int   bn, lt;
  bit   seen;

  initial begin
    #100000;
    $display("FAIL global_timeout: got=still running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{8'h3A, 8'h4C, 1'b0, 1'b0, '{8'h86, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}};
    vt[2] = '{8'h10, 8'h20, 1'b0, 1'b1, '{8'hF0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1}};
    vt[3] = '{8'h05, 8'h03, 1'b1, 1'b0, '{8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}};
    vt[4] = '{8'h20, 8'h10, 1'b0, 1'b1, '{8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}};
    vt[5] = '{8'h55, 8'h55, 1'b1, 1'b1, '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}};
    vt[6] = '{8'h80, 8'h80, 1'b0, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}};
    vt[7] = '{8'h0F, 8'h01, 1'b0, 1'b0, '{8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0; sub16 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({busy, done, s, cy, ac, z, sg, p}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      start_op(vt[i].a, vt[i].b, vt[i].ci, vt[i].sub, vt[i].exp, 1'b1);
      wait_done(bn, lt);
      check("latency", 32'(lt), 32'(NC + 1));
      check("busy_cycles", 32'(bn), 32'(NC));
      repeat (2) @(negedge clk);
      check("hold_idle", 32'({busy, done, s}), 32'({2'b00, vt[i].exp.s}));
    end

    // Start pulse in 2nd RUN cycle is ignored; start held in DONE restarts back-to-back.
    start_op(8'h3A, 8'h4C, 1'b0, 1'b0, vt[0].exp, 1'b1);
    @(negedge clk);
    @(negedge clk);
    a = 8'h11; b = 8'h22; ci = 1'b1; sub = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    check("hs_first_done", 32'(seen), 32'd1);
    a = 8'hFF; b = 8'h01; ci = 1'b0; sub = 1'b0; start = 1'b1;
    q.push_back(vt[1].exp);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("hs_backtoback_busy", 32'({busy, done}), 32'b10);
    wait_done(bn, lt);
    check("hs_second_latency", 32'(lt), 32'(NC));

    // Async reset in the 3rd RUN cycle discards the operation.
    start_op(8'h12, 8'h34, 1'b0, 1'b0, vt[0].exp, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun_reset", 32'({busy, done, s, cy, ac, z, sg, p}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (NC + 2) @(negedge clk);
    check("after_reset_idle", 32'({busy, done, s}), 32'd0);
    start_op(8'h3A, 8'h4C, 1'b0, 1'b0, vt[0].exp, 1'b1);
    wait_done(bn, lt);
    check("post_reset_latency", 32'(lt), 32'(NC + 1));

    // 16-bit, 4-bit chunks: carry-in ripples through all ones.
    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'h0000; ci16 = 1'b1; sub16 = 1'b0; start16 = 1'b1;
    @(posedge clk);
    #1 start16 = 1'b0; a16 = 16'h1234; ci16 = 1'b0;
    seen = 0;
    lt = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lt++;
      if (done16 === 1'b1) seen = 1;
    end
    check("w16_latency", 32'(lt), 32'd5);
    check("w16_result", 32'({s16, cy16, ac16, z16, sg16, p16}),
          32'({16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}));

    repeat (2) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
